// File: rtl/risc_control.sv
// RiSC-16 multi-cycle sequencer: owns PC/IR, fetches over a ready-handshaked
// memory port and drives ALU strobes, operand selects and register-file control.
module risc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] rf_rdata1,
    input  logic [15:0] rf_rdata2,
    input  logic [15:0] alu_out,
    input  logic        eq_out,
    output logic        ADD,
    output logic        NAND,
    output logic        PASS1,
    output logic        EQ,
    output logic [1:0]  src1_sel,
    output logic [1:0]  src2_sel,
    output logic [2:0]  rf_raddr1,
    output logic [2:0]  rf_raddr2,
    output logic [2:0]  rf_waddr,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic [15:0] pc,
    output logic [15:0] pc_plus1,
    output logic [15:0] instr,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_NAND = 3'd2,
        OP_LUI  = 3'd3,
        OP_SW   = 3'd4,
        OP_LW   = 3'd5,
        OP_BEQ  = 3'd6,
        OP_JALR = 3'd7
    } opcode_t;

    localparam logic [1:0] SRC1_RF   = 2'd0;
    localparam logic [1:0] SRC1_LUI  = 2'd2;
    localparam logic [1:0] SRC2_RF   = 2'd0;
    localparam logic [1:0] SRC2_SIMM = 2'd1;
    localparam logic [1:0] WSEL_ALU  = 2'd0;
    localparam logic [1:0] WSEL_MEM  = 2'd1;
    localparam logic [1:0] WSEL_PC   = 2'd2;

    state_t      state, state_next;
    opcode_t     op;
    logic [2:0]  ra, rb, rc;
    logic [15:0] simm_ext;
    logic        is_halt;
    logic [15:0] pc_next;
    logic [15:0] addr_q, addr_next;
    logic        ir_load;
    logic        we_raw;

    assign op       = opcode_t'(instr[15:13]);
    assign ra       = instr[12:10];
    assign rb       = instr[9:7];
    assign rc       = instr[2:0];
    assign simm_ext = {{9{instr[6]}}, instr[6:0]};
    assign is_halt  = (op == OP_JALR) && (instr[6:0] != 7'd0);

    // Register-file addressing is purely a function of the IR.
    assign rf_raddr1 = rb;
    assign rf_raddr2 = (op == OP_SW || op == OP_BEQ) ? ra : rc;
    assign rf_waddr  = ra;
    assign mem_wdata = rf_rdata2;
    assign halted    = (state == S_HALT);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        pc_next    = pc;
        addr_next  = addr_q;
        ir_load    = 1'b0;
        we_raw     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc;
        ADD        = 1'b0;
        NAND       = 1'b0;
        PASS1      = 1'b0;
        EQ         = 1'b0;
        src1_sel   = SRC1_RF;
        src2_sel   = SRC2_RF;
        rf_wsel    = WSEL_ALU;

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: state_next = S_EXEC;

            S_EXEC: begin
                case (op)
                    OP_ADD, OP_ADDI, OP_NAND, OP_LUI: begin
                        ADD        = (op == OP_ADD) || (op == OP_ADDI);
                        NAND       = (op == OP_NAND);
                        PASS1      = (op == OP_LUI);
                        src1_sel   = (op == OP_LUI)  ? SRC1_LUI  : SRC1_RF;
                        src2_sel   = (op == OP_ADDI) ? SRC2_SIMM : SRC2_RF;
                        we_raw     = 1'b1;
                        pc_next    = pc_plus1;
                        state_next = S_FETCH;
                    end
                    OP_SW, OP_LW: begin
                        // Effective address is captured here so the MEM phase
                        // is immune to later changes on the ALU inputs.
                        ADD        = 1'b1;
                        src2_sel   = SRC2_SIMM;
                        addr_next  = alu_out;
                        state_next = S_MEM;
                    end
                    OP_BEQ: begin
                        EQ         = 1'b1;
                        pc_next    = eq_out ? (pc_plus1 + simm_ext) : pc_plus1;
                        state_next = S_FETCH;
                    end
                    OP_JALR: begin
                        if (is_halt) begin
                            pc_next    = pc_plus1;
                            state_next = S_HALT;
                        end else begin
                            we_raw     = 1'b1;
                            rf_wsel    = WSEL_PC;
                            pc_next    = rf_rdata1;
                            state_next = S_FETCH;
                        end
                    end
                endcase
            end

            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                mem_we   = (op == OP_SW);
                if (mem_ready) begin
                    if (op == OP_LW) begin
                        we_raw  = 1'b1;
                        rf_wsel = WSEL_MEM;
                    end
                    pc_next    = pc_plus1;
                    state_next = S_FETCH;
                end
            end

            S_HALT: state_next = S_HALT;

            default: state_next = S_FETCH;
        endcase

        // r0 is hardwired zero; reset silences every request and strobe.
        rf_we = we_raw && (ra != 3'd0) && !rst;
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ADD     = 1'b0;
            NAND    = 1'b0;
            PASS1   = 1'b0;
            EQ      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= 16'h0000;
            pc_plus1 <= 16'h0000;
            instr    <= 16'h0000;
            addr_q   <= 16'h0000;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            addr_q <= addr_next;
            if (ir_load) begin
                instr    <= mem_rdata;
                pc_plus1 <= pc + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_risc_control.sv
// Self-checking bench for risc_control: directed vector table, random
// instructions against a spec-level model, and reset/halt corner sequences.
module tb_risc_control;

    logic        clk, rst;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] rf_rdata1, rf_rdata2, alu_out;
    logic        eq_out;
    logic        ADD, NAND, PASS1, EQ;
    logic [1:0]  src1_sel, src2_sel;
    logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic        rf_we;
    logic [1:0]  rf_wsel;
    logic [15:0] pc, pc_plus1, instr;
    logic        halted;

    risc_control dut (
        .clk(clk), .rst(rst),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .alu_out(alu_out), .eq_out(eq_out),
        .ADD(ADD), .NAND(NAND), .PASS1(PASS1), .EQ(EQ),
        .src1_sel(src1_sel), .src2_sel(src2_sel),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .rf_wsel(rf_wsel),
        .pc(pc), .pc_plus1(pc_plus1), .instr(instr), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] m_pc;

    typedef struct {
        logic [3:0]  strobes;   // {ADD, NAND, PASS1, EQ} in EXEC
        logic [1:0]  src1;
        logic [1:0]  src2;
        logic [2:0]  raddr2;
        logic        we;        // architectural register write happens
        logic [1:0]  wsel;
        logic        is_mem;
        logic        is_store;
        logic        halt;
        logic [15:0] next_pc;
    } exp_t;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] alu;
        logic        eq;
        int          fd;
        int          md;
        logic [3:0]  strobes;
        logic        we;
        logic [1:0]  wsel;
        logic [15:0] next_pc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (pc model %h)", name, act, exp, m_pc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] quiet_vec;
        return {mem_req, mem_we, rf_we, ADD, NAND, PASS1, EQ};
    endfunction

    // Reference model straight from the ISA rules, using integer arithmetic.
    function automatic exp_t model(input logic [15:0] ins, input logic [15:0] cur_pc,
                                   input logic [15:0] r1, input logic eq);
        exp_t e;
        int   p, s;
        p = int'(cur_pc);
        s = int'(ins[6:0]);
        if (s >= 64) s = s - 128;
        e = '{default: '0};
        e.next_pc = 16'((p + 1) & 32'hFFFF);
        e.raddr2  = ins[2:0];
        case (ins[15:13])
            3'd0: begin e.strobes = 4'b1000; e.we = 1'b1; end
            3'd1: begin e.strobes = 4'b1000; e.src2 = 2'd1; e.we = 1'b1; end
            3'd2: begin e.strobes = 4'b0100; e.we = 1'b1; end
            3'd3: begin e.strobes = 4'b0010; e.src1 = 2'd2; e.we = 1'b1; end
            3'd4: begin
                e.strobes = 4'b1000; e.src2 = 2'd1; e.is_mem = 1'b1; e.is_store = 1'b1;
                e.raddr2 = ins[12:10];
            end
            3'd5: begin
                e.strobes = 4'b1000; e.src2 = 2'd1; e.is_mem = 1'b1; e.we = 1'b1; e.wsel = 2'd1;
            end
            3'd6: begin
                e.strobes = 4'b0001; e.raddr2 = ins[12:10];
                if (eq) e.next_pc = 16'((p + 1 + s) & 32'hFFFF);
            end
            default: begin
                if (ins[6:0] == 7'd0) begin
                    e.we = 1'b1; e.wsel = 2'd2; e.next_pc = r1;
                end else begin
                    e.halt = 1'b1;
                end
            end
        endcase
        if (ins[12:10] == 3'd0) e.we = 1'b0;
        return e;
    endfunction

    // Drives one instruction from its FETCH through to the next FETCH (or HALT).
    task automatic run_instr(input logic [15:0] ins, input logic [15:0] r1, input logic [15:0] r2,
                             input logic [15:0] alu, input logic eq, input int fd, input int md,
                             input exp_t e);
        for (int i = 0; i <= fd; i++) begin
            mem_ready = (i == fd);
            mem_rdata = (i == fd) ? ins : 16'($urandom);
            rf_rdata1 = 16'($urandom); rf_rdata2 = 16'($urandom);
            alu_out   = 16'($urandom); eq_out = 1'($urandom);
            #1;
            check("fetch_req", 32'({mem_req, mem_we}), 32'(2'b10));
            check("fetch_addr", 32'(mem_addr), 32'(m_pc));
            check("fetch_quiet", 32'({rf_we, ADD, NAND, PASS1, EQ}), 32'(0));
            tick;
        end
        mem_ready = 1'($urandom); mem_rdata = 16'($urandom);
        #1;
        check("dec_ir", 32'(instr), 32'(ins));
        check("dec_pc_plus1", 32'(pc_plus1), 32'((int'(m_pc) + 1) & 32'hFFFF));
        check("dec_quiet", 32'(quiet_vec()), 32'(0));
        tick;
        rf_rdata1 = r1; rf_rdata2 = r2; alu_out = alu; eq_out = eq;
        mem_ready = 1'($urandom);
        #1;
        check("exec_strobes", 32'({ADD, NAND, PASS1, EQ}), 32'(e.strobes));
        check("exec_sel", 32'({src1_sel, src2_sel}), 32'({e.src1, e.src2}));
        check("exec_raddr", 32'({rf_raddr1, rf_raddr2, rf_waddr}), 32'({ins[9:7], e.raddr2, ins[12:10]}));
        check("exec_we", 32'(rf_we), 32'(e.we && !e.is_mem));
        if (e.we && !e.is_mem) check("exec_wsel", 32'(rf_wsel), 32'(e.wsel));
        check("exec_mem_req", 32'(mem_req), 32'(0));
        check("exec_pc", 32'(pc), 32'(m_pc));
        tick;
        if (e.is_mem) begin
            for (int j = 0; j <= md; j++) begin
                mem_ready = (j == md);
                alu_out   = 16'($urandom); rf_rdata1 = 16'($urandom); rf_rdata2 = r2;
                #1;
                check("mem_req", 32'({mem_req, mem_we}), 32'({1'b1, e.is_store}));
                check("mem_addr", 32'(mem_addr), 32'(alu));
                check("mem_wdata", 32'(mem_wdata), 32'(r2));
                check("mem_rf", 32'({rf_we, rf_wsel}),
                      32'((j == md && !e.is_store) ? {e.we, 2'b01} : 3'b000));
                check("mem_strobes", 32'({ADD, NAND, PASS1, EQ}), 32'(0));
                tick;
            end
        end
        m_pc = e.next_pc;
        mem_ready = 1'b0;
        #1;
        if (e.halt) check("post_halt", 32'({halted, mem_req}), 32'(2'b10));
        else        check("post_fetch", 32'({halted, mem_req, mem_addr}), 32'({2'b01, m_pc}));
        check("post_pc", 32'(pc), 32'(m_pc));
    endtask

    vec_t tbl[13];
    exp_t e;
    logic [15:0] ins, r1, r2, alu;
    logic eq;

    initial begin
        tbl[0]  = '{16'h2405, 16'h0000, 16'h0000, 16'h0005, 1'b0, 0, 0, 4'b1000, 1'b1, 2'd0, 16'h0001};
        tbl[1]  = '{16'hE080, 16'h0010, 16'h0000, 16'h0000, 1'b0, 0, 0, 4'b0000, 1'b0, 2'd2, 16'h0010};
        tbl[2]  = '{16'hC57C, 16'h0003, 16'h0003, 16'h0000, 1'b1, 0, 0, 4'b0001, 1'b0, 2'd0, 16'h000D};
        tbl[3]  = '{16'hE080, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1, 0, 4'b0000, 1'b0, 2'd2, 16'h0010};
        tbl[4]  = '{16'hC57C, 16'h0003, 16'h0004, 16'h0001, 1'b0, 2, 0, 4'b0001, 1'b0, 2'd0, 16'h0011};
        tbl[5]  = '{16'hAC82, 16'h02FE, 16'h0000, 16'h0300, 1'b0, 0, 3, 4'b1000, 1'b1, 2'd1, 16'h0012};
        tbl[6]  = '{16'h8883, 16'h03FD, 16'hBEEF, 16'h0400, 1'b0, 0, 1, 4'b1000, 1'b0, 2'd0, 16'h0013};
        tbl[7]  = '{16'hE080, 16'h0020, 16'h0000, 16'h0000, 1'b0, 0, 0, 4'b0000, 1'b0, 2'd2, 16'h0020};
        tbl[8]  = '{16'hFD00, 16'h1234, 16'h0000, 16'h0000, 1'b0, 0, 0, 4'b0000, 1'b1, 2'd2, 16'h1234};
        tbl[9]  = '{16'h5286, 16'h00F0, 16'h0F0F, 16'hFFFF, 1'b0, 1, 0, 4'b0100, 1'b1, 2'd0, 16'h1235};
        tbl[10] = '{16'h7555, 16'h0000, 16'h0000, 16'h5540, 1'b0, 0, 0, 4'b0010, 1'b1, 2'd0, 16'h1236};
        tbl[11] = '{16'hE080, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 0, 0, 4'b0000, 1'b0, 2'd2, 16'hFFFF};
        tbl[12] = '{16'h0082, 16'h0001, 16'h0002, 16'h0003, 1'b0, 0, 0, 4'b1000, 1'b0, 2'd0, 16'h0000};

        rst = 1'b1; mem_ready = 1'b0; mem_rdata = 16'h0000;
        rf_rdata1 = 16'h0000; rf_rdata2 = 16'h0000; alu_out = 16'h0000; eq_out = 1'b0;
        tick;
        mem_ready = 1'b1;
        #1;
        check("rst_quiet", 32'(quiet_vec()), 32'(0));
        tick;
        check("rst_regs", 32'({pc, instr}), 32'(0));
        check("rst_pcp1_halted", 32'({pc_plus1, halted}), 32'(0));
        rst = 1'b0; mem_ready = 1'b0;
        m_pc = 16'h0000;
        #1;
        check("rst_fetch", 32'({mem_req, mem_addr}), 32'({1'b1, 16'h0000}));

        foreach (tbl[k]) begin
            e = model(tbl[k].ins, m_pc, tbl[k].r1, tbl[k].eq);
            e.strobes = tbl[k].strobes;
            e.we      = tbl[k].we;
            e.wsel    = tbl[k].wsel;
            e.next_pc = tbl[k].next_pc;
            run_instr(tbl[k].ins, tbl[k].r1, tbl[k].r2, tbl[k].alu, tbl[k].eq,
                      tbl[k].fd, tbl[k].md, e);
        end

        for (int k = 0; k < 150; k++) begin
            ins = 16'($urandom);
            if (ins[15:13] == 3'b111) ins[6:0] = 7'd0;
            r1 = 16'($urandom); r2 = 16'($urandom); alu = 16'($urandom); eq = 1'($urandom);
            e = model(ins, m_pc, r1, eq);
            run_instr(ins, r1, r2, alu, eq, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), e);
        end

        // Reset in the middle of a lw's MEM phase with ready: no write-back.
        mem_ready = 1'b1; mem_rdata = 16'hAC82;
        #1; tick;
        mem_ready = 1'b0; tick;
        alu_out = 16'h0777; #1; tick;
        #1;
        check("mrst_mem", 32'({mem_req, mem_addr}), 32'({1'b1, 16'h0777}));
        tick;
        rst = 1'b1; mem_ready = 1'b1;
        #1;
        check("mrst_quiet", 32'(quiet_vec()), 32'(0));
        tick;
        rst = 1'b0; mem_ready = 1'b0;
        m_pc = 16'h0000;
        #1;
        check("mrst_after", 32'({mem_req, pc}), 32'({1'b1, 16'h0000}));

        // Reset mid-FETCH with ready and an instruction on the bus: IR not loaded.
        e = model(16'hE080, m_pc, 16'h0055, 1'b0);
        run_instr(16'hE080, 16'h0055, 16'h0000, 16'h0000, 1'b0, 0, 0, e);
        mem_ready = 1'b0; #1; tick;
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h2405;
        #1;
        check("frst_quiet", 32'(quiet_vec()), 32'(0));
        tick;
        rst = 1'b0; mem_ready = 1'b0;
        m_pc = 16'h0000;
        #1;
        check("frst_pc_ir", 32'({pc, instr}), 32'(0));
        check("frst_pcp1", 32'(pc_plus1), 32'(0));
        check("frst_fetch", 32'({mem_req, mem_addr}), 32'({1'b1, 16'h0000}));

        // Halt is sticky and silent until reset.
        e = model(16'hE001, m_pc, 16'h0000, 1'b0);
        run_instr(16'hE001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0, 0, e);
        for (int k = 0; k < 20; k++) begin
            mem_ready = 1'($urandom); mem_rdata = 16'($urandom);
            #1;
            check("halt_quiet", 32'({quiet_vec(), halted}), 32'(8'h01));
            tick;
        end
        rst = 1'b1; tick;
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        check("halt_cleared", 32'({halted, mem_req, pc}), 32'({2'b01, 16'h0000}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/risc_control.md
# risc_control

Multi-cycle sequencer for the RiSC-16 core, directly upstream of the ALU. Owns the PC and instruction register, fetches over a ready-handshaked memory port, decodes the 3-bit opcode, and drives the ALU opcode strobes (ADD/NAND/PASS1/EQ), operand selects, register-file addresses and write enables. It consumes the ALU's `alu_out` and `eq_out` for address generation and branch resolution.

## Interface
- No parameters; data width fixed at 16, register index 3 bits.
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: clock, rising edge.
  - `rst` in 1: synchronous, active-high reset.
- `mem_ready` in 1: memory completed the current access this cycle.
- `mem_rdata` in 16: memory read data, valid when `mem_ready`=1.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: 1 = write (sw).
- `mem_addr` out 16: memory address.
- `mem_wdata` out 16: equals `rf_rdata2`.
- `rf_rdata1` in 16: register-file port-1 data (combinational read).
- `rf_rdata2` in 16: register-file port-2 data (combinational read).
- `alu_out` in 16: ALU result.
- `eq_out` in 1: ALU equality flag.
- `ADD`, `NAND`, `PASS1`, `EQ` out 1 each: ALU strobes, at most one high.
- `src1_sel` out 2: ALU src1 mux select. 0 = `rf_rdata1`, 2 = lui immediate (`imm10<<6`).
- `src2_sel` out 2: ALU src2 mux select. 0 = `rf_rdata2`, 1 = sign-extended `simm7`.
- `rf_raddr1` out 3: `IR[9:7]` (rB).
- `rf_raddr2` out 3: `IR[12:10]` (rA) for sw/beq, else `IR[2:0]` (rC).
- `rf_waddr` out 3: `IR[12:10]` (rA).
- `rf_we` out 1: register write enable.
- `rf_wsel` out 2: write-data select. 0 = `alu_out`, 1 = `mem_rdata`, 2 = `pc_plus1`.
- `pc` out 16: current PC.
- `pc_plus1` out 16: PC+1 latched at fetch.
- `instr` out 16: IR.
- `halted` out 1: core stopped.

## Operation
- Opcode `IR[15:13]`: 000 add, 001 addi, 010 nand, 011 lui, 100 sw, 101 lw, 110 beq, 111 jalr.
- Halt is opcode 111 with `IR[6:0]`≠0.
- States: FETCH, DECODE, EXEC, MEM, HALT.
- **FETCH:** `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`.
  - When `mem_ready`: IR←`mem_rdata`, `pc_plus1`←`pc`+1, go to DECODE.
  - Otherwise hold all outputs stable.
- **DECODE:** no strobes and no enables. Unconditionally go to EXEC.
- **EXEC**, by opcode:
  - add: ADD, sel 0/0.
  - addi: ADD, sel 0/1.
  - nand: NAND, sel 0/0.
  - lui: PASS1, src1_sel=2.
  - For add, addi, nand and lui: `rf_we`=1, `rf_wsel`=0, PC←`pc_plus1`, go to FETCH.
  - lw/sw: ADD with sel 0/1; address register ← `alu_out`; go to MEM.
  - beq: EQ=1, sel 0/0. PC ← `pc_plus1`+sext(simm7) if `eq_out`, else `pc_plus1`. Go to FETCH.
  - jalr (`IR[6:0]`=0): `rf_we`=1, `rf_wsel`=2, PC←`rf_rdata1`, go to FETCH.
  - halt: PC←`pc_plus1`, go to HALT. No register write.
- **MEM:** `mem_req`=1, `mem_addr`=address register, `mem_we`=1 for sw.
  - On `mem_ready`: lw asserts `rf_we`=1 with `rf_wsel`=1 in that same cycle; both lw and sw set PC←`pc_plus1` and go to FETCH.
- **HALT:** sticky; `halted`=1; all requests and enables low until `rst`.
- `rf_we` is forced to 0 whenever rA=0 (r0 is hardwired zero).
- Strobes, `rf_we` and `mem_req` are 0 in every state or opcode not listed above.
- Arithmetic: PC adds are modulo 2^16, so 0xFFFF+1 = 0x0000. `simm7` is sign-extended from bit 6.

## Timing
- Reset, on the rising edge with `rst`=1: state=FETCH, `pc`=0, `instr`=0, `pc_plus1`=0, address register=0, `halted`=0.
- While `rst`=1, every output enable and strobe is 0 (including `mem_req`).
- Reset asserted mid-access abandons the access. Any `mem_ready` arriving that cycle is ignored, and no `rf_we` is issued.
- `mem_ready` is ignored whenever `mem_req`=0.
- `mem_addr`, `mem_we` and `mem_wdata` stay stable from request until the ready cycle.
- Minimum latencies (ready in the first request cycle):
  - ALU ops, beq, jalr: 3 cycles.
  - lw/sw: 4 cycles.
  - Each wait cycle adds one.
- The PC update and the register write occur on the same edge that leaves EXEC (or MEM, for lw).
- jalr with rA=rB writes the link value and takes the old `rf_rdata1` as target. Both use pre-edge values.

## Test plan
- Reset, then fetch `addi r1,r0,5` (0x2405) with `mem_ready` on the first cycle. Required: EXEC shows ADD=1, src2_sel=1, `rf_we`=1, `rf_waddr`=1; `pc`=1 after 3 cycles.
- beq taken: `eq_out`=1, `pc`=0x0010, simm7=-4. Required: next PC=0x000D. With `eq_out`=0, next PC=0x0011.
- lw with `mem_ready` delayed 3 cycles in MEM. Required: `mem_addr` equals the latched `alu_out` throughout; `rf_we`=1 and `rf_wsel`=1 only on the ready cycle; total 7 cycles.
- jalr r7,r2 with `rf_rdata1`=0x1234 at `pc`=0x0020. Required: `rf_we`=1, `rf_wsel`=2, `pc_plus1`=0x0021; next PC=0x1234.
- `add r0,r1,r2`. Required: ADD=1 and `rf_we`=0. Also: PC 0xFFFF wraps to 0x0000.
- Halt (0xE001) executes. Required: `halted`=1, no `mem_req` for 20 cycles. Separately, `rst` asserted mid-FETCH with `mem_ready`=1 causes no IR load and gives `pc`=0.
